// File: rtl/match_result_fifo.sv
// Capture FIFO for matcher hits: tags each match with a wrapping sequence number, FWFT read port.
// Latency: push visible at head one cycle later; full-without-pop drops the entry and bumps a saturating counter.
module match_result_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH_LOG2 = 6,
  parameter int SEQ_WIDTH  = 8,
  parameter int DROP_WIDTH = 16
) (
  input  logic                            i_fclk,
  input  logic                            i_reset,
  input  logic                            i_result_valid,
  input  logic                            i_result_match,
  input  logic [DATA_WIDTH-1:0]           i_result_data,
  input  logic                            i_clear,
  input  logic                            i_rd_en,
  input  logic [DEPTH_LOG2:0]             i_threshold,
  output logic [SEQ_WIDTH+DATA_WIDTH-1:0] o_rd_data,
  output logic                            o_rd_valid,
  output logic                            o_empty,
  output logic                            o_full,
  output logic [DEPTH_LOG2:0]             o_count,
  output logic [DROP_WIDTH-1:0]           o_drop_count,
  output logic                            o_irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int EW    = SEQ_WIDTH + DATA_WIDTH;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [EW-1:0]         mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;
  logic                  irq_q, irq_d;
  logic [EW-1:0]         last_q, last_d;

  logic empty, full, push_ev, pop_ev, accept, drop_ev, wr_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  always_comb begin
    push_ev  = i_result_valid & i_result_match;
    pop_ev   = i_rd_en & ~empty;
    accept   = push_ev & (~full | pop_ev);
    drop_ev  = push_ev & full & ~pop_ev;
    wr_en    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    seq_d    = seq_q;
    drop_d   = drop_q;
    last_d   = last_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      seq_d    = '0;
      drop_d   = '0;
    end else begin
      if (accept) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      // Remember the popped head so the read port holds it once the FIFO runs dry.
      if (pop_ev) begin
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        last_d   = mem_q[rd_ptr_q];
      end
      if (accept && !pop_ev) begin
        count_d = count_q + (DEPTH_LOG2+1)'(1);
      end else if (pop_ev && !accept) begin
        count_d = count_q - (DEPTH_LOG2+1)'(1);
      end
      if (push_ev) begin
        seq_d = seq_q + SEQ_WIDTH'(1);
      end
      if (drop_ev && (drop_q != '1)) begin
        drop_d = drop_q + DROP_WIDTH'(1);
      end
    end
    irq_d = (i_threshold != '0) && (count_d >= i_threshold);
  end

  always_ff @(posedge i_fclk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
      irq_q    <= 1'b0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
      irq_q    <= irq_d;
      last_q   <= last_d;
    end
  end

  // Storage is not reset; pointers and count define what is live.
  always_ff @(posedge i_fclk) begin
    if (wr_en && !i_reset) begin
      mem_q[wr_ptr_q] <= {seq_q, i_result_data};
    end
  end

  assign o_rd_data    = empty ? last_q : mem_q[rd_ptr_q];
  assign o_rd_valid   = ~empty;
  assign o_empty      = empty;
  assign o_full       = full;
  assign o_count      = count_q;
  assign o_drop_count = drop_q;
  assign o_irq        = irq_q;

endmodule

// File: tb/tb_match_result_fifo.sv
// Directed bench for match_result_fifo with hand-computed expectations.
module tb_match_result_fifo;

  logic        clk = 1'b0;
  logic        i_reset, i_result_valid, i_result_match, i_clear, i_rd_en;
  logic [23:0] i_result_data;
  logic [6:0]  i_threshold;
  logic [31:0] o_rd_data;
  logic        o_rd_valid, o_empty, o_full, o_irq;
  logic [6:0]  o_count;
  logic [15:0] o_drop_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  match_result_fifo dut (
    .i_fclk(clk), .i_reset(i_reset), .i_result_valid(i_result_valid),
    .i_result_match(i_result_match), .i_result_data(i_result_data),
    .i_clear(i_clear), .i_rd_en(i_rd_en), .i_threshold(i_threshold),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_empty(o_empty),
    .o_full(o_full), .o_count(o_count), .o_drop_count(o_drop_count), .o_irq(o_irq)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [23:0] d);
    i_result_valid = 1'b1; i_result_match = 1'b1; i_result_data = d;
    cyc();
    i_result_valid = 1'b0; i_result_match = 1'b0;
  endtask

  task automatic pop();
    i_rd_en = 1'b1;
    cyc();
    i_rd_en = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", o_empty); end
    total++; if (o_rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", o_rd_valid); end
    total++; if (o_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", o_full); end
    total++; if (o_count !== 7'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", o_count); end
    total++; if (o_drop_count !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", o_drop_count); end
    total++; if (o_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", o_irq); end
    total++; if (o_rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", o_rd_data); end
  endtask

  task automatic test_basic();
    logic [31:0] exp [3];
    exp[0] = 32'h000000AA; exp[1] = 32'h010000BB; exp[2] = 32'h020000CC;
    do_reset();
    push(24'h0000AA);
    i_result_valid = 1'b1; i_result_match = 1'b0; i_result_data = 24'h0000DD;
    cyc();
    i_result_valid = 1'b0; i_result_match = 1'b1; i_result_data = 24'h0000EE;
    cyc();
    i_result_match = 1'b0;
    total++; if (o_rd_data !== exp[0] || o_rd_valid !== 1'b1) begin bad++; $display("FAIL basic_first_visible got=%h/%b want=%h/1", o_rd_data, o_rd_valid, exp[0]); end
    push(24'h0000BB);
    push(24'h0000CC);
    total++; if (o_count !== 7'd3) begin bad++; $display("FAIL basic_count got=%0d want=3", o_count); end
    for (int i = 0; i < 3; i++) begin
      total++; if (o_rd_data !== exp[i]) begin bad++; $display("FAIL basic_read%0d got=%h want=%h", i, o_rd_data, exp[i]); end
      pop();
    end
    total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL basic_empty got=%b want=1", o_empty); end
    total++; if (o_rd_data !== exp[2]) begin bad++; $display("FAIL basic_hold got=%h want=%h", o_rd_data, exp[2]); end
    pop();
    total++; if (o_count !== 7'd0) begin bad++; $display("FAIL basic_underflow got=%0d want=0", o_count); end
  endtask

  task automatic test_overflow();
    int errs;
    do_reset();
    for (int i = 0; i < 66; i++) push(24'(i));
    total++; if (o_full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b want=1", o_full); end
    total++; if (o_count !== 7'd64) begin bad++; $display("FAIL ovf_count got=%0d want=64", o_count); end
    total++; if (o_drop_count !== 16'd2) begin bad++; $display("FAIL ovf_drop got=%0d want=2", o_drop_count); end
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      if (o_rd_data !== {8'(i), 24'(i)}) errs++;
      pop();
    end
    total++; if (errs != 0) begin bad++; $display("FAIL ovf_drain_tags got=%0d bad entries want=0", errs); end
    push(24'hC0FFEE);
    total++; if (o_rd_data !== 32'h42C0FFEE) begin bad++; $display("FAIL ovf_next_tag got=%h want=42c0ffee", o_rd_data); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 64; i++) push(24'h000100 + 24'(i));
    i_rd_en = 1'b1;
    push(24'hABCDEF);
    i_rd_en = 1'b0;
    total++; if (o_count !== 7'd64 || o_full !== 1'b1) begin bad++; $display("FAIL fullpp_count got=%0d want=64", o_count); end
    total++; if (o_drop_count !== 16'd0) begin bad++; $display("FAIL fullpp_drop got=%0d want=0", o_drop_count); end
    total++; if (o_rd_data !== 32'h01000101) begin bad++; $display("FAIL fullpp_head got=%h want=01000101", o_rd_data); end
    for (int i = 0; i < 63; i++) pop();
    total++; if (o_rd_data !== 32'h40ABCDEF || o_count !== 7'd1) begin bad++; $display("FAIL fullpp_tail got=%h want=40abcdef", o_rd_data); end
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    i_rd_en = 1'b1;
    push(24'h55AA55);
    i_rd_en = 1'b0;
    total++; if (o_count !== 7'd1) begin bad++; $display("FAIL emptypp_count got=%0d want=1", o_count); end
    total++; if (o_rd_data !== 32'h0055AA55 || o_rd_valid !== 1'b1) begin bad++; $display("FAIL emptypp_data got=%h want=0055aa55", o_rd_data); end
  endtask

  task automatic test_irq();
    do_reset();
    i_threshold = 7'd4;
    for (int i = 0; i < 3; i++) push(24'(i));
    total++; if (o_irq !== 1'b0) begin bad++; $display("FAIL irq_below got=%b want=0", o_irq); end
    push(24'h3);
    total++; if (o_irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b want=1", o_irq); end
    pop();
    total++; if (o_irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b want=0", o_irq); end
    i_threshold = 7'd0;
    for (int i = 0; i < 61; i++) push(24'(i));
    total++; if (o_irq !== 1'b0 || o_count !== 7'd64) begin bad++; $display("FAIL irq_disabled got=%b/%0d want=0/64", o_irq, o_count); end
  endtask

  task automatic setup_busy();
    do_reset();
    for (int i = 0; i < 67; i++) push(24'(i));
    i_rd_en = 1'b1;
    for (int i = 0; i < 221; i++) push(24'h100 + 24'(i));
    for (int i = 0; i < 54; i++) cyc();
    i_rd_en = 1'b0;
  endtask

  task automatic test_clear();
    setup_busy();
    total++; if (o_count !== 7'd10 || o_drop_count !== 16'd3) begin bad++; $display("FAIL clr_setup got=%0d/%0d want=10/3", o_count, o_drop_count); end
    i_clear = 1'b1;
    push(24'h777777);
    i_clear = 1'b0;
    total++; if (o_count !== 7'd0 || o_empty !== 1'b1) begin bad++; $display("FAIL clr_count got=%0d want=0", o_count); end
    total++; if (o_drop_count !== 16'd0) begin bad++; $display("FAIL clr_drop got=%0d want=0", o_drop_count); end
    push(24'h123456);
    total++; if (o_rd_data !== 32'h00123456) begin bad++; $display("FAIL clr_tag got=%h want=00123456", o_rd_data); end

    setup_busy();
    i_reset = 1'b1;
    i_clear = 1'b1;
    push(24'h777777);
    i_reset = 1'b0;
    i_clear = 1'b0;
    total++; if (o_count !== 7'd0 || o_empty !== 1'b1 || o_drop_count !== 16'd0) begin bad++; $display("FAIL rst_state got=%0d/%0d want=0/0", o_count, o_drop_count); end
    total++; if (o_rd_data !== 32'h0) begin bad++; $display("FAIL rst_rd_data got=%h want=0", o_rd_data); end
    push(24'h654321);
    total++; if (o_rd_data !== 32'h00654321) begin bad++; $display("FAIL rst_tag got=%h want=00654321", o_rd_data); end
  endtask

  initial begin
    i_reset = 1'b1; i_result_valid = 1'b0; i_result_match = 1'b0; i_result_data = '0;
    i_clear = 1'b0; i_rd_en = 1'b0; i_threshold = '0;
    cyc();
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_irq();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
